led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Downstream consumer of the divided clock: samples the divider's slow_clk output in the clk domain and advances an LED pattern once per slow_clk rising edge.
- Supports four selectable patterns, plus pause. Drives the board LEDs directly.
- Fully synchronous to clk; slow_clk is never used as a clock.

Parameters:
- N_LEDS, 8, number of LED outputs; legal range 2..16.
- PWM_BITS, 4, width of the brightness input and PWM counter. Used only when PWM_DIM_EN is defined.

Ports:
- clk  input  1  system clock; the same clock that drives the divider.
- rst  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided clock from the divider, registered in the clk domain.
- mode  input  2  pattern select: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT.
- pause  input  1  when high, slow_clk edges are discarded and the pattern freezes.
- brightness  input  PWM_BITS  dim level. Always present; ignored without PWM_DIM_EN.
- leds  output  N_LEDS  LED drive, active high.
- step_tick  output  1  one-cycle pulse when the pattern advances.

Behaviour:
- Registers:
  - pattern[N_LEDS-1:0]
  - dir: 0 = up, 1 = down
  - slow_prev
  - mode_q
  - step_tick
- Reset (rst high at a clk edge, overrides everything):
  - pattern=0, dir=0, slow_prev=1, mode_q=0, step_tick=0, so leds=0.
  - slow_prev resets to 1 so that slow_clk already high at reset release does not cause a spurious step.
- Every cycle, slow_prev <= slow_clk, including while paused.
- Step condition: slow_clk & ~slow_prev & ~pause & (mode == mode_q).
- Latency: leds and step_tick update at the clk edge that samples the first high slow_clk. Both are visible 1 clk after slow_clk rises.
- step_tick is high for exactly that one cycle; otherwise it is 0.
- Mode change (mode != mode_q):
  - mode_q <= mode.
  - pattern loads the start value of the new mode; dir <= 0; step_tick=0.
  - Mode change takes priority over a coinciding step, and that step is lost.
  - Start values: BLINK 0, CHASE 1, BOUNCE 1, COUNT 0.
  - Because mode_q resets to BLINK, a non-BLINK mode loads its start value on the first cycle after reset.
- Step transitions:
  - BLINK: pattern <= ~pattern, alternating all-zeros and all-ones.
  - CHASE: rotate left by 1; MSB wraps to bit 0.
  - BOUNCE: one-hot. When dir=0, shift left; when dir=1, shift right.
    - Arriving at the MSB sets dir=1; arriving at bit 0 sets dir=0.
    - End positions are not repeated. For N=4: 0001,0010,0100,1000,0100,0010,0001,0010...
  - COUNT: pattern <= pattern+1 modulo 2^N_LEDS; all-ones wraps to 0.
- Defensive recovery:
  - In CHASE or BOUNCE, a step on a non-one-hot pattern reloads 1 with dir=0.
  - This state is unreachable in normal operation.
- pause:
  - Rising edges that occur while pause is high are dropped, not queued.
  - Deasserting pause does not create a step, even if slow_clk is high.
- Mid-operation reset: takes effect at the next edge; the pattern restarts from reset values.

Optional Feature:
- Macro: PWM_DIM_EN.
- Defined:
  - A free-running PWM_BITS counter pwm_cnt (reset 0, +1 every clk, wraps).
  - leds = pattern & {N_LEDS{on}}, where on = (pwm_cnt < brightness) | (brightness all-ones).
  - brightness 0 gives leds=0; all-ones gives leds=pattern continuously.
  - step_tick and pattern are unaffected.
- Not defined: leds = pattern; brightness is unused; no counter is present.

Test Plan (N_LEDS=4):
- Reset with slow_clk=1 and mode=1, then release. Cycle 1: leds=0001, no step_tick. No step until slow_clk goes 0 then 1; then leds=0010 and step_tick high for 1 cycle, 1 clk after the rise.
- mode=2, 8 slow_clk rising edges → leds sequence 0010,0100,1000,0100,0010,0001,0010,0100.
- mode=3, 17 edges → leds 0001..1111 then 0000, then 0001. step_tick count = 17.
- mode=0 with pause=1 across 3 edges → leds unchanged, no step_tick. Release pause while slow_clk=1 → no step. Next edge → leds toggles.
- mode 3→1 on the same cycle as a slow_clk edge → leds=0001, step_tick=0. Next edge → 0010.
- PWM_DIM_EN defined, pattern 1111:
  - brightness=4: leds=1111 for 4 of every 16 clks.
  - brightness=0: leds always 0000.
  - brightness=15: leds always 1111.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: advances one of four patterns on each rising edge of slow_clk sampled in the clk domain.
// Optional PWM dimming of the LED outputs is compiled in with `define PWM_DIM_EN.
module led_pattern_sequencer #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slow_clk,
  input  logic [1:0]          mode,
  input  logic                pause,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   leds,
  output logic                step_tick
);

  typedef enum logic [1:0] {
    M_BLINK  = 2'd0,
    M_CHASE  = 2'd1,
    M_BOUNCE = 2'd2,
    M_COUNT  = 2'd3
  } mode_e;

  localparam logic [N_LEDS-1:0] ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic [N_LEDS-1:0] pattern_q, pattern_d;
  logic              dir_q, dir_d;
  logic              slow_prev_q, slow_prev_d;
  mode_e             mode_q, mode_d;
  logic              step_tick_q, step_tick_d;

  mode_e             mode_in;
  logic              mode_chg;
  logic              rise;
  logic              one_hot;
  logic [N_LEDS-1:0] shl, shr;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign rise     = slow_clk & ~slow_prev_q & ~pause;
  assign one_hot  = (pattern_q != '0) && ((pattern_q & (pattern_q - ONE)) == '0);
  assign shl      = {pattern_q[N_LEDS-2:0], 1'b0};
  assign shr      = {1'b0, pattern_q[N_LEDS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= '0;
      dir_q       <= 1'b0;
      slow_prev_q <= 1'b1;
      mode_q      <= M_BLINK;
      step_tick_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      dir_q       <= dir_d;
      slow_prev_q <= slow_prev_d;
      mode_q      <= mode_d;
      step_tick_q <= step_tick_d;
    end
  end

  always_comb begin
    pattern_d   = pattern_q;
    dir_d       = dir_q;
    slow_prev_d = slow_clk;
    mode_d      = mode_q;
    step_tick_d = 1'b0;

    // A mode change wins over a coinciding edge; that edge is lost.
    if (mode_chg) begin
      mode_d = mode_in;
      dir_d  = 1'b0;
      unique case (mode_in)
        M_CHASE, M_BOUNCE: pattern_d = ONE;
        default:           pattern_d = '0;
      endcase
    end else if (rise) begin
      step_tick_d = 1'b1;
      unique case (mode_q)
        M_BLINK: pattern_d = ~pattern_q;
        M_CHASE: begin
          if (one_hot) begin
            pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
          end else begin
            pattern_d = ONE;
            dir_d     = 1'b0;
          end
        end
        M_BOUNCE: begin
          if (!one_hot) begin
            pattern_d = ONE;
            dir_d     = 1'b0;
          end else if (!dir_q) begin
            pattern_d = shl;
            dir_d     = shl[N_LEDS-1];
          end else begin
            pattern_d = shr;
            dir_d     = ~shr[0];
          end
        end
        default: pattern_d = pattern_q + ONE;
      endcase
    end
  end

  assign step_tick = step_tick_q;

`ifdef PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
  end

  // Full-scale brightness must be on every cycle, not 15 of 16.
  assign pwm_on = (pwm_cnt_q < brightness) || (&brightness);
  assign leds   = pattern_q & {N_LEDS{pwm_on}};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign leds              = pattern_q;
`endif

endmodule
